// File: rtl/noc_packet_receiver_pkg.sv
// noc_packet_receiver_pkg: shared NoC field widths, flit bit positions, marker values and FIFO entry layout.
package noc_packet_receiver_pkg;
  localparam int Noc_Data_Width = 32;
  localparam int Noc_ID_X_Width = 4;
  localparam int Noc_ID_Y_Width = 4;
  localparam int Noc_Point_H = 28;
  localparam int Noc_Source_Point = 20;
  localparam int Axi_Len_Point = 12;
  localparam int Noc_Point_E = 8;
  localparam logic [Noc_Data_Width-Noc_Point_H-1:0] Noc_Head_H = 4'hA;
  localparam logic [Noc_Data_Width-Noc_Point_H-1:0] Noc_Tail_H = 4'hF;
  localparam logic [Axi_Len_Point-Noc_Point_E-1:0] Noc_Head_E = 4'h5;
  localparam logic [Axi_Len_Point-Noc_Point_E-1:0] Noc_Tail_E = 4'hC;
  typedef struct packed {
    logic                      last;
    logic [Noc_ID_X_Width-1:0] src_x;
    logic [Noc_ID_Y_Width-1:0] src_y;
    logic [Noc_Data_Width-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/noc_packet_receiver_fifo.sv
// noc_rx_fifo: synchronous payload FIFO with full/empty flags; head data reads as zero when empty.
module noc_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/noc_packet_receiver.sv
// noc_packet_receiver: NoC endpoint that strips header/tail flits and streams payload with source ID.
// Define NOC_RX_CHECK_EN to enable header/tail marker and destination checking.
module noc_packet_receiver
  import noc_packet_receiver_pkg::*;
#(
  parameter logic [Noc_ID_X_Width-1:0] X_ID = '0,
  parameter logic [Noc_ID_Y_Width-1:0] Y_ID = '0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      receive_valid,
  output logic                      receive_ready,
  input  logic [Noc_Data_Width-1:0] receive_flit,
  input  logic                      receive_is_header,
  input  logic                      receive_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Noc_Data_Width-1:0] out_data,
  output logic [Noc_ID_X_Width-1:0] out_src_x,
  output logic [Noc_ID_Y_Width-1:0] out_src_y,
  output logic                      out_last,
  output logic                      pkt_done,
  output logic [15:0]               pkt_cnt,
  output logic [7:0]                err_cnt
);
`ifdef NOC_RX_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif
  typedef enum logic [1:0] {RX_HEADER, RX_PAYLOAD, RX_DISCARD} rx_state_e;
  rx_state_e state, state_nxt;
  logic ready_en, full, empty, acc, hdr_match, tail_match, hdr_ok, tail_ok;
  logic take_hdr, flush, take_tail, take_data, stray, bad_hdr, bad_tail, push, done;
  logic hold_valid;
  logic [Noc_Data_Width-1:0] hold_data;
  logic [Noc_ID_X_Width-1:0] src_x_q;
  logic [Noc_ID_Y_Width-1:0] src_y_q;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  rx_entry_t push_entry, head;
  assign receive_ready = ready_en & ~full;
  assign acc = receive_valid & receive_ready;
  // destination ID sits just below the source ID field
  assign hdr_match = receive_flit[Noc_Data_Width-1:Noc_Point_H] == Noc_Head_H
                  && receive_flit[Axi_Len_Point-1:Noc_Point_E] == Noc_Head_E
                  && receive_flit[Noc_Source_Point-1 -: Noc_ID_X_Width] == X_ID
                  && receive_flit[Noc_Source_Point-Noc_ID_X_Width-1 -: Noc_ID_Y_Width] == Y_ID;
  assign tail_match = receive_flit[Noc_Data_Width-1:Noc_Point_H] == Noc_Tail_H
                   && receive_flit[Axi_Len_Point-1:Noc_Point_E] == Noc_Tail_E;
  assign hdr_ok = ~CheckEn | hdr_match;
  assign tail_ok = ~CheckEn | tail_match;
  assign take_hdr = acc & receive_is_header & (state != RX_DISCARD);
  assign flush = take_hdr & (state == RX_PAYLOAD);
  assign take_tail = acc & ~receive_is_header & receive_is_tail & (state == RX_PAYLOAD);
  assign take_data = acc & ~receive_is_header & ~receive_is_tail & (state == RX_PAYLOAD);
  assign stray = acc & ~receive_is_header & (state == RX_HEADER);
  assign bad_hdr = take_hdr & ~hdr_ok;
  assign bad_tail = take_tail & ~tail_ok;
  assign push = (flush | take_tail | take_data) & hold_valid;
  assign done = (take_hdr & receive_is_tail & hdr_ok) | take_tail;
  assign err_inc = 2'(flush) + 2'(bad_hdr) + 2'(stray) + 2'(bad_tail);
  assign err_sum = {1'b0, err_cnt} + 9'(err_inc);
  assign push_entry = {~take_data, src_x_q, src_y_q, hold_data};
  always_comb begin
    state_nxt = state;
    if (take_hdr) state_nxt = receive_is_tail ? RX_HEADER : hdr_ok ? RX_PAYLOAD : RX_DISCARD;
    else if (acc && receive_is_tail && state != RX_HEADER) state_nxt = RX_HEADER;
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n)
    if (!noc_rst_n) begin
      state <= RX_HEADER;
      ready_en <= 1'b0;
      hold_valid <= 1'b0;
      hold_data <= '0;
      src_x_q <= '0;
      src_y_q <= '0;
      pkt_done <= 1'b0;
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      ready_en <= 1'b1;
      pkt_done <= done;
      if (done) pkt_cnt <= pkt_cnt + 16'd1;
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (take_data) begin
        hold_valid <= 1'b1;
        hold_data <= receive_flit;
      end else if (flush | take_tail) hold_valid <= 1'b0;
      if (take_hdr & hdr_ok & ~receive_is_tail) begin
        src_x_q <= receive_flit[Noc_Point_H-1 -: Noc_ID_X_Width];
        src_y_q <= receive_flit[Noc_Point_H-Noc_ID_X_Width-1 -: Noc_ID_Y_Width];
      end
    end
  noc_rx_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(noc_clk),
    .rst_n(noc_rst_n),
    .push(push),
    .wdata(push_entry),
    .pop(out_ready),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign out_valid = ~empty;
  assign out_data = head.data;
  assign out_src_x = head.src_x;
  assign out_src_y = head.src_y;
  assign out_last = head.last;
endmodule

// File: tb/tb_noc_packet_receiver.sv
// tb_noc_packet_receiver: vector table, directed corner cases and random traffic against a packet-level model.
module tb_noc_packet_receiver;
  import noc_packet_receiver_pkg::*;
`ifdef NOC_RX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic noc_clk = 1'b0, noc_rst_n = 1'b0;
  logic receive_valid = 1'b0, receive_is_header = 1'b0, receive_is_tail = 1'b0, out_ready = 1'b0;
  logic [31:0] receive_flit = '0;
  logic receive_ready, out_valid, out_last, pkt_done;
  logic [31:0] out_data;
  logic [3:0] out_src_x, out_src_y;
  logic [15:0] pkt_cnt;
  logic [7:0] err_cnt;

  noc_packet_receiver dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .receive_valid(receive_valid), .receive_ready(receive_ready), .receive_flit(receive_flit),
    .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src_x(out_src_x), .out_src_y(out_src_y), .out_last(out_last),
    .pkt_done(pkt_done), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct packed {logic last; logic [3:0] sx; logic [3:0] sy; logic [31:0] data;} beat_t;
  typedef struct {bit h; bit t; logic [31:0] f; logic [15:0] pkt; logic [7:0] err;} vec_t;

  int checks = 0, errors = 0;
  int m_pkts, m_err, done_seen, beats_seen;
  bit m_in_pkt, m_discard, m_have_prev, rand_ready;
  logic [31:0] m_prev;
  logic [3:0] m_sx, m_sy;
  beat_t exp_q[$];
  beat_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [3:0] sx, sy, dx, dy);
    return {Noc_Head_H, sx, sy, dx, dy, Noc_Head_E, 8'h00};
  endfunction

  function automatic logic [31:0] mk_tail();
    return {Noc_Tail_H, 20'h0, Noc_Tail_E, 8'h00};
  endfunction

  // Packet-level reference: a data flit becomes visible once the next flit of its packet arrives.
  function void m_err_inc();
    if (m_err < 255) m_err++;
  endfunction

  function void m_release(input bit last);
    if (m_have_prev) exp_q.push_back({last, m_sx, m_sy, m_prev});
    m_have_prev = 0;
  endfunction

  function void model_accept(input bit h, input bit t, input logic [31:0] f);
    bit ok;
    if (m_discard) begin
      if (t) m_discard = 0;
      return;
    end
    if (h) begin
      if (m_in_pkt) begin
        m_release(1);
        m_err_inc();
        m_in_pkt = 0;
      end
      ok = !CHK || (f[31:28] == Noc_Head_H && f[11:8] == Noc_Head_E && f[19:12] == 8'h00);
      if (!ok) begin
        m_err_inc();
        if (!t) m_discard = 1;
      end else if (t) m_pkts++;
      else begin
        m_in_pkt = 1;
        m_sx = f[27:24];
        m_sy = f[23:20];
      end
    end else if (!m_in_pkt) m_err_inc();
    else if (t) begin
      m_release(1);
      m_pkts++;
      m_in_pkt = 0;
      if (CHK && !(f[31:28] == Noc_Tail_H && f[11:8] == Noc_Tail_E)) m_err_inc();
    end else begin
      m_release(0);
      m_prev = f;
      m_have_prev = 1;
    end
  endfunction

  function void model_reset();
    m_pkts = 0; m_err = 0; done_seen = 0;
    m_in_pkt = 0; m_discard = 0; m_have_prev = 0;
    exp_q.delete();
  endfunction

  always @(negedge noc_clk) begin
    #4;
    if (pkt_done) done_seen++;
    if (noc_rst_n && out_valid && out_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) chk("beat_unexpected", 64'(exp_q.size()), 64'd1);
      else begin
        mon_e = exp_q.pop_front();
        chk("beat", 64'({out_last, out_src_x, out_src_y, out_data}), 64'(mon_e));
      end
    end
  end

  task automatic send(input bit h, input bit t, input logic [31:0] f);
    int n = 0;
    receive_valid = 1; receive_is_header = h; receive_is_tail = t; receive_flit = f;
    while (1) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      if (receive_ready) begin
        model_accept(h, t, f);
        @(negedge noc_clk);
        break;
      end
      if (++n > 200) begin
        chk("accept_timeout", 64'(receive_ready), 64'd1);
        break;
      end
      @(negedge noc_clk);
    end
    receive_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    rand_ready = 0;
    out_ready = 1;
    while ((out_valid || exp_q.size() != 0) && n < 100) begin
      @(negedge noc_clk);
      n++;
    end
    repeat (2) @(negedge noc_clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("pkt_cnt", 64'(pkt_cnt), 64'(16'(m_pkts)));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    chk("pkt_done_pulses", 64'(done_seen), 64'(m_pkts));
  endtask

  task automatic do_reset();
    noc_rst_n = 0; receive_valid = 0; out_ready = 0; rand_ready = 0;
    model_reset();
    @(negedge noc_clk);
    chk("reset_outputs", 64'({out_valid, out_last, out_src_x, out_src_y, pkt_done, receive_ready, out_data}), 64'd0);
    chk("reset_counters", 64'({pkt_cnt, err_cnt}), 64'd0);
    noc_rst_n = 1;
    chk("ready_before_edge", 64'(receive_ready), 64'd0);
    @(negedge noc_clk);
    chk("ready_after_edge", 64'(receive_ready), 64'd1);
  endtask

  initial begin
    vec_t tbl[10];
    int b0, r;
    logic [3:0] dx, dy;
    tbl[0] = '{0, 0, 32'h1234_5678, 16'd0, 8'd1};
    tbl[1] = '{1, 0, mk_hdr(4'd1, 4'd1, 4'd0, 4'd0), 16'd0, 8'd1};
    tbl[2] = '{0, 0, 32'hA5A5_0001, 16'd0, 8'd1};
    tbl[3] = '{0, 1, mk_tail(), 16'd1, 8'd1};
    tbl[4] = '{1, 1, mk_hdr(4'd3, 4'd4, 4'd0, 4'd0), 16'd2, 8'd1};
    tbl[5] = '{1, 0, mk_hdr(4'd2, 4'd3, 4'd0, 4'd0), 16'd2, 8'd1};
    tbl[6] = '{0, 0, 32'hDEAD_BEEF, 16'd2, 8'd1};
    tbl[7] = '{1, 0, mk_hdr(4'd5, 4'd6, 4'd0, 4'd0), 16'd2, 8'd2};
    tbl[8] = '{0, 1, mk_tail(), 16'd3, 8'd2};
    tbl[9] = '{0, 1, mk_tail(), 16'd3, 8'd3};
    beats_seen = 0;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].h, tbl[i].t, tbl[i].f);
      chk($sformatf("vec%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(tbl[i].pkt));
      chk($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(tbl[i].err));
    end
    drain();

    b0 = beats_seen;
    send(1, 0, mk_hdr(4'd7, 4'd2, 4'd0, 4'd0));
    for (int i = 0; i < 3; i++) send(0, 0, 32'hC0DE_0000 + i);
    send(0, 1, mk_tail());
    drain();
    chk("three_beats", 64'(beats_seen - b0), 64'd3);

    do_reset();
    b0 = beats_seen;
    send(1, 0, mk_hdr(4'd1, 4'd2, 4'd0, 4'd0));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("ready_before_full", 64'(receive_ready), 64'd1);
      send(0, 0, 32'hF1F0_0000 + i);
    end
    chk("ready_low_when_full", 64'(receive_ready), 64'd0);
    chk("out_valid_when_full", 64'(out_valid), 64'd1);
    out_ready = 1;
    send(0, 0, 32'hF1F0_0009);
    send(0, 1, mk_tail());
    drain();
    chk("ten_beats", 64'(beats_seen - b0), 64'd10);

    do_reset();
    b0 = beats_seen;
    out_ready = 1;
    send(1, 0, mk_hdr(4'd1, 4'd1, 4'd2, 4'd3));
    send(0, 0, 32'h0BAD_0001);
    send(0, 1, mk_tail());
    drain();
`ifdef NOC_RX_CHECK_EN
    chk("wrong_dest_err", 64'(err_cnt), 64'd1);
    chk("wrong_dest_pkts", 64'(pkt_cnt), 64'd0);
    chk("wrong_dest_beats", 64'(beats_seen - b0), 64'd0);
`else
    chk("wrong_dest_err", 64'(err_cnt), 64'd0);
    chk("wrong_dest_pkts", 64'(pkt_cnt), 64'd1);
    chk("wrong_dest_beats", 64'(beats_seen - b0), 64'd1);
`endif

    do_reset();
    out_ready = 0;
    send(1, 0, mk_hdr(4'd3, 4'd3, 4'd0, 4'd0));
    send(0, 0, 32'h1111_0001);
    send(0, 0, 32'h1111_0002);
    chk("mid_pkt_out_valid", 64'(out_valid), 64'd1);
    do_reset();
    chk("after_reset_empty", 64'(out_valid), 64'd0);
    out_ready = 1;
    send(1, 0, mk_hdr(4'd4, 4'd5, 4'd0, 4'd0));
    send(0, 0, 32'h2222_0001);
    send(0, 1, mk_tail());
    drain();
    chk("after_reset_pkt_cnt", 64'(pkt_cnt), 64'd1);

    do_reset();
    out_ready = 1;
    for (int i = 0; i < 260; i++) send(0, 0, 32'(i));
    chk("err_saturated", 64'(err_cnt), 64'hFF);
    drain();

    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      dx = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      dy = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      if (r < 4) send(1, 0, mk_hdr(4'($urandom), 4'($urandom), dx, dy));
      else if (r == 4) send(1, 1, mk_hdr(4'($urandom), 4'($urandom), dx, dy));
      else if (r < 8) send(0, 1, mk_tail());
      else send(0, 0, $urandom);
      if ($urandom_range(0, 4) == 0) @(negedge noc_clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
